// File: rtl/gpio_pkg.sv
// Shared constants and sizing helper for the GPIO input conditioning path.
// Pure declarations: no logic, no latency, no flow control.
package gpio_pkg;

    localparam int GPIO_WIDTH       = 8;
    localparam int DEFAULT_DEBOUNCE = 4;

    // Counter width able to hold 0..cycles; never narrower than one bit.
    function automatic int cnt_width(input int cycles);
        int w;
        w = $clog2(cycles + 1);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/gpio_pin_debouncer_debounce_bit.sv
// One pin: 2-flop synchroniser, debounce counter, clean level and sticky edge flags.
// Latency D+2 edges from pin change to pin_clean; no backpressure, sample_en only pauses counting.
module debounce_bit
    import gpio_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE,
    parameter int CNT_W           = cnt_width(DEFAULT_DEBOUNCE)
) (
    input  logic clk,
    input  logic clr,
    input  logic pin_raw,
    input  logic sample_en,
    input  logic flag_clear,
    output logic pin_clean,
    output logic rise_flag,
    output logic fall_flag
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             clean_q, clean_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d = pin_raw;
        sync2_d = sync1_q;
        cnt_d   = cnt_q;
        clean_d = clean_q;
        // Clear first so that a same-edge transition re-sets the flag.
        rise_d  = rise_q & ~flag_clear;
        fall_d  = fall_q & ~flag_clear;

        if (sync2_q == clean_q) begin
            cnt_d = '0;
        end else if (sample_en) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d   = '0;
                clean_d = sync2_q;
                if (sync2_q) begin
                    rise_d = 1'b1;
                end else begin
                    fall_d = 1'b1;
                end
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            clean_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign pin_clean = clean_q;
    assign rise_flag = rise_q;
    assign fall_flag = fall_q;

endmodule

// File: rtl/gpio_pin_debouncer.sv
// Per-bit synchronise/debounce of a GPIO port with sticky edge flags and a maskable irq.
// Latency D+2 edges to pin_clean, irq combinational from flags; no backpressure.
module gpio_pin_debouncer
    import gpio_pkg::*;
#(
    parameter int WIDTH           = GPIO_WIDTH,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] pin_raw,
    input  logic             sample_en,
    input  logic [WIDTH-1:0] rise_mask,
    input  logic [WIDTH-1:0] fall_mask,
    input  logic [WIDTH-1:0] flag_clear,
    output logic [WIDTH-1:0] pin_clean,
    output logic [WIDTH-1:0] rise_flag,
    output logic [WIDTH-1:0] fall_flag,
    output logic             irq
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_bit (
            .clk        (clk),
            .clr        (clr),
            .pin_raw    (pin_raw[i]),
            .sample_en  (sample_en),
            .flag_clear (flag_clear[i]),
            .pin_clean  (pin_clean[i]),
            .rise_flag  (rise_flag[i]),
            .fall_flag  (fall_flag[i])
        );
    end

    assign irq = |((rise_flag & rise_mask) | (fall_flag & fall_mask));

endmodule

// File: tb/tb_gpio_pin_debouncer.sv
// Bench for gpio_pin_debouncer: directed scenarios then random pins, with a queue-based
// scoreboard fed by a behavioural per-pin model and drained by a negedge monitor.
module tb_gpio_pin_debouncer;

    localparam int W = 8;
    localparam int D = 4;

    logic         clk;
    logic         clr;
    logic [W-1:0] pin_raw;
    logic         sample_en;
    logic [W-1:0] rise_mask;
    logic [W-1:0] fall_mask;
    logic [W-1:0] flag_clear;
    logic [W-1:0] pin_clean;
    logic [W-1:0] rise_flag;
    logic [W-1:0] fall_flag;
    logic         irq;

    gpio_pin_debouncer #(
        .WIDTH           (W),
        .DEBOUNCE_CYCLES (D),
        .CNT_W           (8)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .pin_raw    (pin_raw),
        .sample_en  (sample_en),
        .rise_mask  (rise_mask),
        .fall_mask  (fall_mask),
        .flag_clear (flag_clear),
        .pin_clean  (pin_clean),
        .rise_flag  (rise_flag),
        .fall_flag  (fall_flag),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h expected=%h at %0t", nm, got, want, $time);
        end
    endtask

    // Behavioural model: pin history plus "how many qualifying ticks the
    // synchronised level has disagreed with the clean level".
    logic [W-1:0] m_s1, m_s2, m_clean, m_rise, m_fall;
    int           m_run [W];

    typedef struct {
        logic [W-1:0] clean;
        logic [W-1:0] rise;
        logic [W-1:0] fall;
        logic         irq;
    } exp_t;
    exp_t sb_q[$];

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_clean = '0; m_rise = '0; m_fall = '0;
        for (int b = 0; b < W; b++) m_run[b] = 0;
    endtask

    task automatic model_edge();
        logic [W-1:0] nc, rose, fell;
        if (clr) return;
        nc = m_clean; rose = '0; fell = '0;
        for (int b = 0; b < W; b++) begin
            if (m_s2[b] == m_clean[b]) begin
                m_run[b] = 0;
            end else if (sample_en) begin
                m_run[b] = m_run[b] + 1;
                if (m_run[b] >= D) begin
                    nc[b] = m_s2[b];
                    m_run[b] = 0;
                    if (m_s2[b]) rose[b] = 1'b1; else fell[b] = 1'b1;
                end
            end
        end
        m_rise  = (m_rise & ~flag_clear) | rose;
        m_fall  = (m_fall & ~flag_clear) | fell;
        m_clean = nc;
        m_s2    = m_s1;
        m_s1    = pin_raw;
    endtask

    // Values to apply after the next edge.
    logic [W-1:0] raw_v, fc_v, rm_v, fm_v;
    logic         en_v, clr_v;

    task automatic step();
        exp_t e;
        @(posedge clk);
        model_edge();
        #2;
        pin_raw    = raw_v;
        sample_en  = en_v;
        clr        = clr_v;
        flag_clear = fc_v;
        rise_mask  = rm_v;
        fall_mask  = fm_v;
        if (clr_v) model_reset();
        e.clean = m_clean;
        e.rise  = m_rise;
        e.fall  = m_fall;
        e.irq   = |((m_rise & rm_v) | (m_fall & fm_v));
        sb_q.push_back(e);
    endtask

    task automatic count_to(input int b, input string nm);
        int n;
        n = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            n++;
            if (pin_clean[b]) break;
        end
        chk(nm, 32'(n), 32'd6);
    endtask

    // Monitor: compares every presented output cycle against the queued expectation.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("sb_pin_clean", 32'(pin_clean), 32'(e.clean));
                chk("sb_rise_flag", 32'(rise_flag), 32'(e.rise));
                chk("sb_fall_flag", 32'(fall_flag), 32'(e.fall));
                chk("sb_irq", 32'(irq), 32'(e.irq));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        raw_v = '0; fc_v = '0; rm_v = '0; fm_v = '0; en_v = 1'b1; clr_v = 1'b1;
        pin_raw = '0; flag_clear = '0; rise_mask = '0; fall_mask = '0;
        sample_en = 1'b1; clr = 1'b1;
        model_reset();
        repeat (3) step();
        chk("reset_clean", 32'(pin_clean), 32'd0);
        chk("reset_irq", 32'(irq), 32'd0);
        clr_v = 1'b0;
        repeat (3) step();

        // Reset with all pins high, mid-simulation.
        raw_v = 8'hFF;
        repeat (10) step();
        chk("pre_reset_clean", 32'(pin_clean), 32'hFF);
        rm_v = 8'hFF;
        clr_v = 1'b1;
        step();
        #1;
        chk("async_reset_clean", 32'(pin_clean), 32'd0);
        chk("async_reset_flags", 32'({rise_flag, fall_flag}), 32'd0);
        chk("async_reset_irq", 32'(irq), 32'd0);
        step();
        clr_v = 1'b0;
        step();
        count_to(0, "reset_release_latency");
        chk("reset_release_clean", 32'(pin_clean), 32'hFF);
        chk("reset_release_rise", 32'(rise_flag), 32'hFF);

        // Clean press on bit 0.
        rm_v = '0;
        raw_v = 8'h00; fc_v = 8'hFF;
        repeat (10) step();
        fc_v = '0;
        repeat (2) step();
        raw_v = 8'h01; rm_v = 8'h01;
        step();
        count_to(0, "press_latency");
        chk("press_rise", 32'(rise_flag), 32'h01);
        chk("press_fall", 32'(fall_flag), 32'h00);
        chk("press_irq", 32'(irq), 32'd1);

        // Bounce on bit 3: 1,1,0,0,1,1,0,0 then settle high.
        for (int i = 0; i < 8; i++) begin
            raw_v[3] = ((i / 2) % 2) == 0;
            step();
            chk("bounce_hold_low", 32'(pin_clean[3]), 32'd0);
        end
        raw_v[3] = 1'b1;
        step();
        count_to(3, "bounce_settle_latency");
        chk("bounce_rise", 32'(rise_flag[3]), 32'd1);

        // Gated ticks on bit 7.
        raw_v[7] = 1'b1;
        for (int i = 0; i < 40; i++) begin
            en_v = (i % 5) == 4;
            step();
        end
        en_v = 1'b1;
        chk("gated_clean7", 32'(pin_clean[7]), 32'd1);

        // Clear/set race on bit 2.
        fc_v = 8'hFF; raw_v[2] = 1'b1;
        step();
        fc_v = '0;
        repeat (8) step();
        chk("race_pre_rise2", 32'(rise_flag[2]), 32'd1);
        raw_v[2] = 1'b0;
        step();
        repeat (4) step();
        fc_v = 8'h04;
        step();
        fc_v = '0;
        step();
        chk("race_rise2", 32'(rise_flag[2]), 32'd0);
        chk("race_fall2", 32'(fall_flag[2]), 32'd1);
        rm_v = 8'h04; fm_v = 8'h04; fc_v = 8'h04;
        step();
        fc_v = '0;
        step();
        chk("clear_only_flags2", 32'({rise_flag[2], fall_flag[2]}), 32'd0);
        chk("clear_only_irq", 32'(irq), 32'd0);

        // Reset while bit 5 is mid-count.
        raw_v[5] = 1'b1;
        step();
        repeat (3) step();
        clr_v = 1'b1;
        step();
        clr_v = 1'b0;
        step();
        count_to(5, "rst_mid_latency");

        // Random phase.
        for (int i = 0; i < 500; i++) begin
            for (int b = 0; b < W; b++) begin
                if ($urandom_range(0, 7) == 0) raw_v[b] = ~raw_v[b];
            end
            en_v  = $urandom_range(0, 3) != 0;
            fc_v  = ($urandom_range(0, 3) == 0) ? W'($urandom) : '0;
            if ($urandom_range(0, 9) == 0) begin
                rm_v = W'($urandom);
                fm_v = W'($urandom);
            end
            clr_v = $urandom_range(0, 99) == 0;
            step();
        end
        clr_v = 1'b0;
        step();

        repeat (2) @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gpio_pin_debouncer.md
Name: gpio_pin_debouncer

Overview:
- Input conditioning stage that sits directly upstream of the gpio block. Its pin_clean output drives PINA_input_data (or PINB_input_data).
- Raw external pins (switches, buttons, board headers) are asynchronous and bouncy. This block synchronises them into the clk domain and debounces each bit independently.
- Produces sticky per-bit rising/falling edge flags and a maskable interrupt request, modelling ATmega32A pin-change / external interrupt sources for the emulator core.

Parameters:
- WIDTH, 8, number of pins conditioned (one GPIO port).
- DEBOUNCE_CYCLES, 4, number of qualifying sample ticks a changed level must persist before pin_clean follows it (legal range 1..255).
- CNT_W, 8, width of each per-bit debounce counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock (the divided 100 Hz clock in the GPIO test top).
- clr  input  1  asynchronous, active-high reset.
- pin_raw  input  WIDTH  unsynchronised external pin levels.
- sample_en  input  1  debounce tick qualifier; tie to 1 to count every clk cycle.
- rise_mask  input  WIDTH  per-bit enable of rising-edge flags into irq.
- fall_mask  input  WIDTH  per-bit enable of falling-edge flags into irq.
- flag_clear  input  WIDTH  write-1-to-clear strobe, applied to both rise_flag and fall_flag of that bit.
- pin_clean  output  WIDTH  debounced level; feeds PINx_input_data.
- rise_flag  output  WIDTH  sticky: pin_clean bit went 0->1.
- fall_flag  output  WIDTH  sticky: pin_clean bit went 1->0.
- irq  output  1  |((rise_flag & rise_mask) | (fall_flag & fall_mask)); combinational from registered flags.

Behaviour:
- Reset: while clr=1, all of the following are forced to 0 immediately and asynchronously: sync stage 1 and 2, pin_clean, counters, rise_flag, fall_flag. irq is therefore 0. Any debounce in progress is discarded.
- Synchroniser: two flops per bit, sync1 <= pin_raw, sync2 <= sync1. Fixed 2-cycle latency, no reset-release special case.
- Per-bit debounce FSM (the counter acts as state; STABLE when cnt=0, PENDING otherwise). On each rising clk edge:
  - sync2 == pin_clean: cnt <= 0. A glitch shorter than the window is fully rejected and the count restarts.
  - sync2 != pin_clean and sample_en=0: cnt holds.
  - sync2 != pin_clean, sample_en=1, cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - sync2 != pin_clean, sample_en=1, cnt == DEBOUNCE_CYCLES-1: pin_clean <= sync2, cnt <= 0, and the matching edge flag is set on the same edge.
- Latency with sample_en=1, DEBOUNCE_CYCLES=D:
  - pin_raw changes before edge N.
  - sync2 reflects the change after edge N+1.
  - pin_clean and the flag update at edge N+1+D, i.e. D+2 edges after the change (6 for D=4).
- D=1: pin_clean follows sync2 one qualifying tick later. No counter state is needed beyond the compare.
- Flags:
  - set <= rising (old 0 -> new 1) or falling (old 1 -> new 0) transition of pin_clean.
  - A flag bit remains 1 until flag_clear for that bit is 1.
  - Simultaneous set and clear on the same edge: set wins, flag stays 1.
  - Clearing an already-0 flag has no effect.
- Bits are fully independent. Simultaneous changes on multiple bits each debounce and flag separately.
- irq has no added latency beyond the flag registers. Changing a mask affects irq in the same cycle.
- No overflow: cnt never exceeds DEBOUNCE_CYCLES-1.

Decomposition:
- Shared package gpio_pkg:
  - GPIO_WIDTH = 8
  - DEFAULT_DEBOUNCE = 4
  - localparam helper for CNT_W (clog2 of DEBOUNCE_CYCLES+1)
- One sub-module, debounce_bit: synchroniser, counter, clean register and the two edge flags for one pin. It is instantiated WIDTH times via generate.
- The top level holds only the irq reduction.

Test Plan:
- Reset/default: assert clr with pin_raw=8'hFF mid-simulation. Required: pin_clean=0, flags=0, irq=0 immediately. After release with sample_en=1, pin_clean=8'hFF exactly 6 edges later, rise_flag=8'hFF.
- Clean press on bit 0, D=4, sample_en=1: pin_raw 8'h00->8'h01 held steady. Required: pin_clean=8'h01 at edge 6, rise_flag=8'h01, fall_flag=0. With rise_mask=8'h01, irq=1 in the same cycle.
- Bounce rejection: pin_raw bit 3 toggles 1,0,1,0 every 2 cycles, then settles at 1. Required: pin_clean[3] stays 0 through the bouncing and goes 1 only 6 edges after the final settle. Exactly one rise_flag[3] set.
- sample_en gating: sample_en pulses 1 cycle in every 5, pin_raw bit 7 rises. Required: pin_clean[7] updates on the 4th qualifying pulse after sync2 changes; the counter holds between pulses.
- Flag clear race: rise_flag[2]=1, then drive flag_clear=8'h04 on the same edge bit 2 completes a new 1->0 debounce. Required: fall_flag[2]=1, rise_flag[2]=0. A later clear-only strobe leaves both at 0 and irq=0.
- Reset mid-debounce: raise pin_raw bit 5, assert clr for 1 cycle at count=2, then release. Required: counter restarts from 0, and pin_clean[5] rises exactly 6 edges after the release edge.
